shifter_seq: RTL and testbench

Parametrised multi-cycle shifter, the sequential successor to the 32-bit combinational shifter_32. It supports the same four shift types. Operands are accepted over a valid/ready handshake, and the data is shifted by up to STEP bit positions per clock. The result is presented over a valid/ready handshake, so the block trades latency for area in datapaths that cannot afford a full barrel shifter.

---
 rtl/shifter_seq.sv | 122 ++++++++++++
 tb/tb_shifter_seq.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/shifter_seq.sv
// Multi-cycle shifter: accepts an operand over valid/ready, shifts it by at most
// STEP positions per clock, and presents the result over valid/ready.
module shifter_seq #(
  parameter  int unsigned WIDTH   = 32,
  parameter  int unsigned STEP    = 1,
  localparam int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_type,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [1:0] T_LSL = 2'd0;
  localparam logic [1:0] T_LSR = 2'd1;
  localparam logic [1:0] T_ASR = 2'd2;
  localparam logic [1:0] T_ROR = 2'd3;

  // Remaining count never exceeds WIDTH-1, so saturating STEP there loses nothing.
  localparam int unsigned        STEP_SAT = (STEP >= WIDTH) ? (WIDTH - 1) : STEP;
  localparam logic [SHAMT_W-1:0] STEP_K   = SHAMT_W'(STEP_SAT);

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   data_q,  data_d;
  logic [SHAMT_W-1:0] rem_q,   rem_d;
  logic [1:0]         type_q,  type_d;
  logic [WIDTH-1:0]   out_q,   out_d;

  logic [SHAMT_W-1:0] step_k;
  logic [SHAMT_W:0]   rot_amt;
  logic [WIDTH-1:0]   step_res;
  logic [SHAMT_W-1:0] rem_next;

  always_comb begin
    step_k   = (rem_q > STEP_K) ? STEP_K : rem_q;
    rot_amt  = (SHAMT_W+1)'(WIDTH) - (SHAMT_W+1)'(step_k);
    rem_next = rem_q - step_k;
  end

  // The sign bit stays in the MSB after each arithmetic step, so repeated
  // partial shifts replicate the original sign.
  always_comb begin
    step_res = data_q;
    case (type_q)
      T_LSL:   step_res = data_q << step_k;
      T_LSR:   step_res = data_q >> step_k;
      T_ASR:   step_res = WIDTH'($signed(data_q) >>> step_k);
      T_ROR:   step_res = (data_q >> step_k) | (data_q << rot_amt);
      default: step_res = data_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rem_d   = rem_q;
    type_d  = type_q;
    out_d   = out_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          data_d = in_data;
          rem_d  = in_shamt;
          type_d = in_type;
          if (in_shamt == '0) begin
            out_d   = in_data;
            state_d = S_DONE;
          end else begin
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        data_d = step_res;
        rem_d  = rem_next;
        if (rem_next == '0) begin
          out_d   = step_res;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      rem_q   <= '0;
      type_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      type_q  <= type_d;
      out_q   <= out_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q == S_SHIFT);
  assign out_valid = (state_q == S_DONE);
  assign out_data  = out_q;

endmodule

// File: tb/tb_shifter_seq.sv
// Bench for shifter_seq: three instances (STEP 1, 4, 32) driven in lockstep and
// checked cycle by cycle against an index-arithmetic reference of the shift rules.
module tb_shifter_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic [1:0]  in_type;
  logic        out_ready;

  logic        ir [3];
  logic        ov [3];
  logic        bz [3];
  logic [31:0] od [3];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  shifter_seq #(.WIDTH(32), .STEP(1)) u_s1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]),
    .in_data(in_data), .in_shamt(in_shamt), .in_type(in_type),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .busy(bz[0])
  );

  shifter_seq #(.WIDTH(32), .STEP(4)) u_s4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]),
    .in_data(in_data), .in_shamt(in_shamt), .in_type(in_type),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .busy(bz[1])
  );

  shifter_seq #(.WIDTH(32), .STEP(32)) u_s32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]),
    .in_data(in_data), .in_shamt(in_shamt), .in_type(in_type),
    .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]), .busy(bz[2])
  );

  function automatic int step_of(input int i);
    return (i == 0) ? 1 : (i == 1) ? 4 : 32;
  endfunction

  // Result bit i is taken from the source bit the shift rule points at.
  function automatic logic [31:0] ref_shift(input logic [31:0] d, input int s,
                                            input logic [1:0] t);
    logic [31:0] r;
    int j;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      j = i + s;
      case (t)
        2'd0:    r[i] = (i >= s) ? d[i - s] : 1'b0;
        2'd1:    r[i] = (j < 32) ? d[j] : 1'b0;
        2'd2:    r[i] = (j < 32) ? d[j] : d[31];
        default: r[i] = d[j % 32];
      endcase
    end
    return r;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic do_op(input logic [31:0] d, input int s, input logic [1:0] t, input int hold);
    logic [31:0] exp;
    int lat [3];
    int maxlat;
    exp    = ref_shift(d, s, t);
    maxlat = 0;
    for (int i = 0; i < 3; i++) begin
      lat[i] = (s + step_of(i) - 1) / step_of(i);
      if (lat[i] > maxlat) maxlat = lat[i];
      check_eq($sformatf("idle_ready[%0d]", i), 32'(ir[i]), 32'd1);
    end
    in_valid = 1'b1;
    in_data  = d;
    in_shamt = 5'(s);
    in_type  = t;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = $urandom;
    in_shamt = 5'($urandom);
    in_type  = 2'($urandom);
    for (int c = 0; c <= maxlat + hold; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      for (int i = 0; i < 3; i++) begin
        check_eq($sformatf("out_valid[%0d]", i), 32'(ov[i]), 32'(c >= lat[i]));
        check_eq($sformatf("busy[%0d]", i),      32'(bz[i]), 32'(c < lat[i]));
        check_eq($sformatf("in_ready[%0d]", i),  32'(ir[i]), 32'd0);
        if (c >= lat[i])
          check_eq($sformatf("out_data[%0d] s=%0d t=%0d", i, s, t), od[i], exp);
      end
      in_valid = 1'($urandom);
      in_data  = $urandom;
      in_shamt = 5'($urandom);
      in_type  = 2'($urandom);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("taken_valid[%0d]", i), 32'(ov[i]), 32'd0);
      check_eq($sformatf("taken_ready[%0d]", i), 32'(ir[i]), 32'd1);
      check_eq($sformatf("taken_busy[%0d]", i),  32'(bz[i]), 32'd0);
      check_eq($sformatf("taken_data[%0d]", i),  od[i], exp);
    end
  endtask

  task automatic reset_mid_shift();
    in_valid = 1'b1;
    in_data  = 32'h8000_0000;
    in_shamt = 5'd31;
    in_type  = 2'd2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("rst_valid[%0d]", i), 32'(ov[i]), 32'd0);
      check_eq($sformatf("rst_busy[%0d]", i),  32'(bz[i]), 32'd0);
      check_eq($sformatf("rst_data[%0d]", i),  od[i], 32'd0);
    end
    #2 rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++)
      check_eq($sformatf("rst_ready[%0d]", i), 32'(ir[i]), 32'd1);
    repeat (40) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("no_stale_valid[%0d]", i), 32'(ov[i]), 32'd0);
      check_eq($sformatf("no_stale_data[%0d]", i),  od[i], 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shamt  = '0;
    in_type   = '0;
    out_ready = 1'b0;
    #2;
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("reset_valid[%0d]", i), 32'(ov[i]), 32'd0);
      check_eq($sformatf("reset_busy[%0d]", i),  32'(bz[i]), 32'd0);
      check_eq($sformatf("reset_data[%0d]", i),  od[i], 32'd0);
    end
    #6 rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++)
      check_eq($sformatf("reset_ready[%0d]", i), 32'(ir[i]), 32'd1);

    check_eq("ref_lsl5", ref_shift(32'h0000_0F00, 5, 2'd0), 32'h0001_E000);
    check_eq("ref_asr8", ref_shift(32'h8000_0F00, 8, 2'd2), 32'hFF80_000F);
    check_eq("ref_ror12", ref_shift(32'h0000_0F00, 12, 2'd3), 32'hF000_0000);

    do_op(32'h0000_0F00, 5,  2'd0, 0);
    do_op(32'h0000_0F00, 5,  2'd1, 0);
    do_op(32'h8000_0F00, 8,  2'd2, 0);
    do_op(32'h8000_0F00, 8,  2'd1, 0);
    do_op(32'h0000_0F00, 12, 2'd3, 0);
    do_op(32'h0000_0F00, 0,  2'd0, 0);
    do_op(32'h0000_0F00, 5,  2'd0, 10);
    do_op(32'h8000_0000, 31, 2'd2, 0);
    do_op(32'h0000_0001, 31, 2'd0, 0);
    do_op(32'hDEAD_BEEF, 31, 2'd3, 2);
    do_op(32'h7FFF_FFFF, 4,  2'd2, 1);

    reset_mid_shift();

    for (int n = 0; n < 40; n++)
      do_op($urandom, int'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
